// File: rtl/pixel_rx_pkg.sv
// Shared types and constants for the pixel frame receiver.
// State encoding, the sync marker byte and counter width helpers.
package pixel_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DRAIN,
        WAIT_TX
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Width needed to hold the values 0..max_value inclusive.
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

    // Width needed to index n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word-fallthrough byte FIFO: pop_data shows the head entry whenever empty is low.
// A push while full is taken only if a pop happens in the same cycle.
module byte_fifo
    import pixel_rx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic [7:0]                    push_data,
    input  logic                          pop,
    output logic [7:0]                    pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int AW = idx_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage has no reset; stale entries are unreachable once the pointers are cleared.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_frame_rx.sv
// Frame receiver: UART bytes -> FIFO -> pixel stream with RTS flow control and frame framing.
// Define PIXEL_RX_SYNC_EN to require a SYNC_BYTE marker in IDLE before each frame.
module pixel_frame_rx
    import pixel_rx_pkg::*;
#(
    parameter int FRAME_W    = 40,
    parameter int FRAME_H    = 30,
    parameter int FIFO_DEPTH = 16,
    parameter int RTS_MARGIN = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_data_rdy,
    output logic                        rts,
    output logic [7:0]                  pix_data,
    output logic                        pix_valid,
    input  logic                        pix_ready,
    output logic [$clog2(FRAME_W)-1:0]  pix_x,
    output logic [$clog2(FRAME_H)-1:0]  pix_y,
    output logic                        frame_start,
    output logic                        frame_done,
    input  logic                        results_sent,
    output logic                        overflow
);

    localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
    localparam int CNT_W = cnt_width(FRAME_PIXELS);
    localparam int FCW   = $clog2(FIFO_DEPTH + 1);
    localparam int XW    = $clog2(FRAME_W);
    localparam int YW    = $clog2(FRAME_H);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_PIXELS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [FCW-1:0]   RTS_LEVEL = FCW'(FIFO_DEPTH - RTS_MARGIN);
    localparam logic [XW-1:0]    X_ONE     = XW'(1);
    localparam logic [XW-1:0]    X_LAST    = XW'(FRAME_W - 1);
    localparam logic [YW-1:0]    Y_ONE     = YW'(1);
    localparam logic [YW-1:0]    Y_LAST    = YW'(FRAME_H - 1);

    rx_state_t         state;
    rx_state_t         next_state;
    logic [CNT_W-1:0]  rx_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCW-1:0]    fifo_count;
    logic              in_rx_state;
    logic              pix_byte_ok;
    logic              accept;
    logic              drop;
    logic              last_byte;
    logic              xfer;
    logic              last_xfer;
    logic              frame_end_ack;

    assign in_rx_state = (state == IDLE) || (state == RECV);

`ifdef PIXEL_RX_SYNC_EN
    logic sync_hit;
    assign sync_hit    = rx_data_rdy && (state == IDLE) && (rx_data == SYNC_BYTE);
    assign pix_byte_ok = (state == RECV);
`else
    assign pix_byte_ok = in_rx_state;
`endif

    // A full FIFO can still take a byte when the detector drains one in the same cycle.
    assign accept    = rx_data_rdy && pix_byte_ok && (!fifo_full || xfer);
    assign drop      = rx_data_rdy && ((pix_byte_ok && fifo_full && !xfer) ||
                                       (state == DRAIN) || (state == WAIT_TX));
    assign last_byte = accept && (rx_cnt == CNT_LAST);

    assign pix_valid     = !fifo_empty;
    assign xfer          = pix_valid && pix_ready;
    assign last_xfer     = xfer && (pix_x == X_LAST) && (pix_y == Y_LAST);
    assign frame_start   = xfer && (pix_x == '0) && (pix_y == '0);
    assign frame_end_ack = (state == WAIT_TX) && results_sent;

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (accept),
        .push_data (rx_data),
        .pop       (xfer),
        .pop_data  (pix_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The final byte moves straight to DRAIN so its transfer is always seen there.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
`ifdef PIXEL_RX_SYNC_EN
                if (sync_hit) begin
                    next_state = RECV;
                end
`else
                if (last_byte) begin
                    next_state = DRAIN;
                end else if (accept) begin
                    next_state = RECV;
                end
`endif
            end
            RECV: begin
                if (last_byte) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (last_xfer) begin
                    next_state = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (results_sent) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_cnt <= '0;
        end else if (frame_end_ack) begin
            rx_cnt <= '0;
        end else if (accept) begin
            rx_cnt <= rx_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_x <= '0;
            pix_y <= '0;
        end else if (xfer) begin
            if (pix_x == X_LAST) begin
                pix_x <= '0;
                pix_y <= (pix_y == Y_LAST) ? '0 : pix_y + Y_ONE;
            end else begin
                pix_x <= pix_x + X_ONE;
            end
        end else if (frame_end_ack) begin
            pix_x <= '0;
            pix_y <= '0;
        end
    end

    // RTS leaves RTS_MARGIN slots for bytes the laptop already has in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rts        <= 1'b1;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            rts        <= in_rx_state && (fifo_count < RTS_LEVEL) && (rx_cnt < CNT_FRAME);
            frame_done <= last_xfer;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_frame_rx.sv
// Directed bench for pixel_frame_rx with a scoreboard of expected pixels.
// Build with PIXEL_RX_SYNC_EN to also exercise the sync-byte framing.
module tb_pixel_frame_rx;

    localparam int FW = 4;
    localparam int FH = 2;
    localparam int BW = 8;
    localparam int BH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_rdy = 1'b0;
    logic       rts;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready = 1'b0;
    logic [1:0] pix_x;
    logic       pix_y;
    logic       frame_start;
    logic       frame_done;
    logic       results_sent = 1'b0;
    logic       overflow;

    logic [7:0] rx_data_b = 8'h00;
    logic       rx_data_rdy_b = 1'b0;
    logic       rts_b;
    logic [7:0] pix_data_b;
    logic       pix_valid_b;
    logic       pix_ready_b = 1'b0;
    logic [2:0] pix_x_b;
    logic [1:0] pix_y_b;
    logic       frame_start_b;
    logic       frame_done_b;
    logic       results_sent_b = 1'b0;
    logic       overflow_b;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int mx = 0;
    int my = 0;
    bit prev_stall = 1'b0;
    bit prev_last = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    pixel_frame_rx #(.FRAME_W(FW), .FRAME_H(FH), .FIFO_DEPTH(16), .RTS_MARGIN(4)) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
        .rts(rts), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .frame_done(frame_done),
        .results_sent(results_sent), .overflow(overflow)
    );

    pixel_frame_rx #(.FRAME_W(BW), .FRAME_H(BH), .FIFO_DEPTH(16), .RTS_MARGIN(4)) dut_big (
        .clock(clock), .reset(reset), .rx_data(rx_data_b), .rx_data_rdy(rx_data_rdy_b),
        .rts(rts_b), .pix_data(pix_data_b), .pix_valid(pix_valid_b), .pix_ready(pix_ready_b),
        .pix_x(pix_x_b), .pix_y(pix_y_b), .frame_start(frame_start_b), .frame_done(frame_done_b),
        .results_sent(results_sent_b), .overflow(overflow_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit expect_out);
        rx_data = b;
        rx_data_rdy = 1'b1;
        if (expect_out) exp_q.push_back(b);
        @(posedge clock);
        #1;
        rx_data_rdy = 1'b0;
    endtask

    task automatic applyStimulusBig(input logic [7:0] b);
        rx_data_b = b;
        rx_data_rdy_b = 1'b1;
        @(posedge clock);
        #1;
        rx_data_rdy_b = 1'b0;
    endtask

    task automatic sendResults();
        results_sent = 1'b1;
        @(posedge clock);
        #1;
        results_sent = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput("drain", exp_q.size(), 0);
    endtask

    // Scoreboard side: every transfer pops the oldest expected pixel and advances the x/y model.
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_last = 1'b0;
            mx = 0;
            my = 0;
            exp_q.delete();
        end else begin
            bit xfer;
            xfer = pix_valid && pix_ready;
            if (prev_stall) begin
                checkOutput("hold_valid", pix_valid, 1);
                checkOutput("hold_data", pix_data, prev_data);
            end
            if (frame_done) begin
                done_cnt++;
                checkOutput("done_after_last", prev_last, 1);
            end
            checkOutput("frame_start", frame_start, xfer && mx == 0 && my == 0);
            if (xfer) begin
                checkOutput("xfer_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) checkOutput("pix_data", pix_data, exp_q.pop_front());
                checkOutput("pix_x", pix_x, mx);
                checkOutput("pix_y", pix_y, my);
                prev_last = (mx == FW - 1) && (my == FH - 1);
                if (mx == FW - 1) begin
                    mx = 0;
                    my = (my == FH - 1) ? 0 : my + 1;
                end else begin
                    mx++;
                end
            end else begin
                prev_last = 1'b0;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_data = pix_data;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // reset state
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_rts", rts, 1);
        checkOutput("rst_valid", pix_valid, 0);
        checkOutput("rst_x", pix_x, 0);
        checkOutput("rst_y", pix_y, 0);
        checkOutput("rst_done", frame_done, 0);
        checkOutput("rst_ovf", overflow, 0);
        checkOutput("rst_rts_b", rts_b, 1);
        reset = 1'b0;
        waitCycles(1);
        checkOutput("rts_after_release", rts, 1);

        // test 1: one frame, detector always ready
        pix_ready = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(8'(i), 1'b1);
        waitDrain(20);
        waitCycles(2);
        checkOutput("t1_done_cnt", done_cnt, 1);
        checkOutput("t1_rts_wait", rts, 0);
        checkOutput("t1_ovf", overflow, 0);
        checkOutput("t1_valid", pix_valid, 0);
        sendResults();
        checkOutput("t1_rts_lag", rts, 0);
        waitCycles(1);
        checkOutput("t1_rts_rearm", rts, 1);

        // test 2: RTS threshold and FIFO full on the larger frame
        for (int i = 0; i < 11; i++) applyStimulusBig(8'(8'h40 + i));
        waitCycles(2);
        checkOutput("t2_rts_occ11", rts_b, 1);
        applyStimulusBig(8'h4B);
        waitCycles(2);
        checkOutput("t2_rts_occ12", rts_b, 0);
        for (int i = 12; i < 16; i++) applyStimulusBig(8'(8'h40 + i));
        waitCycles(1);
        checkOutput("t2_ovf_at_full", overflow_b, 0);
        applyStimulusBig(8'h50);
        waitCycles(1);
        checkOutput("t2_ovf_dropped", overflow_b, 1);
        pix_ready_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            checkOutput("t2_valid", pix_valid_b, 1);
            checkOutput("t2_data", pix_data_b, 8'h40 + i);
            checkOutput("t2_x", pix_x_b, i % BW);
        end
        waitCycles(1);
        checkOutput("t2_empty", pix_valid_b, 0);

        // test 3: bytes arriving in WAIT_TX are dropped
        for (int i = 0; i < 8; i++) applyStimulus(8'(8'h10 + i), 1'b1);
        waitDrain(20);
        applyStimulus(8'hEE, 1'b0);
        applyStimulus(8'hEF, 1'b0);
        waitCycles(3);
        checkOutput("t3_ovf", overflow, 1);
        checkOutput("t3_done_cnt", done_cnt, 2);
        checkOutput("t3_valid", pix_valid, 0);
        sendResults();
        waitCycles(1);
        checkOutput("t3_rts_rearm", rts, 1);
        checkOutput("t3_ovf_sticky", overflow, 1);

        // test 4: detector ready toggling every cycle
        pix_ready = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus(8'(8'h20 + i), 1'b1);
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) begin
            pix_ready = ~pix_ready;
            waitCycles(1);
        end
        checkOutput("t4_drain", exp_q.size(), 0);
        pix_ready = 1'b1;
        waitCycles(2);
        checkOutput("t4_done_cnt", done_cnt, 3);
        sendResults();
        waitCycles(1);

        // test 5: reset in the middle of a frame
        pix_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(8'(8'h30 + i), 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("t5_valid_async", pix_valid, 0);
        checkOutput("t5_rts_async", rts, 1);
        checkOutput("t5_ovf_cleared", overflow, 0);
        waitCycles(2);
        reset = 1'b0;
        waitCycles(1);
        checkOutput("t5_rts_release", rts, 1);
        pix_ready = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(8'(8'h80 + i), 1'b1);
        waitDrain(20);
        waitCycles(2);
        checkOutput("t5_done_cnt", done_cnt, 4);
        sendResults();
        waitCycles(1);

`ifdef PIXEL_RX_SYNC_EN
        // test 6: stray byte and sync marker are not pixels
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'hA5, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(8'(8'h60 + i), 1'b1);
        waitDrain(20);
        waitCycles(2);
        checkOutput("t6_ovf", overflow, 0);
        checkOutput("t6_done_cnt", done_cnt, 5);
        sendResults();
        waitCycles(1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
